// File: rtl/count_sequencer.sv
// Run/pause/clear controller for the 8-bit ripple-enable counter: turns
// asynchronous button levels into a rate-selectable step enable and a clear pulse.
module count_sequencer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned DIV_W    = 26
) (
  input  logic       clock,
  input  logic       Resetn,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       clear_req,
  input  logic [1:0] rate_sel,
  input  logic       wrap_en,
  input  logic [7:0] count,
  output logic       cnt_enable,
  output logic       cnt_clearn,
  output logic [1:0] state,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [DIV_W-1:0] BASE = DIV_W'(TICK_DIV);

  state_t           cur, nxt;
  logic [2:0]       sync1, sync2, prev;  // bit 2 clear, bit 1 stop, bit 0 start
  logic [2:0]       req_edge;
  logic [DIV_W-1:0] div_cnt, div_nxt, period_m1;
  logic             tick, en_nxt, clrn_nxt;

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {clear_req, stop_req, start_req};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign req_edge = sync2 & ~prev;

  // >= rather than == so a lowered period takes effect immediately
  assign period_m1 = (BASE >> rate_sel) - DIV_W'(1);
  assign tick      = (cur == RUN) && (div_cnt >= period_m1);

  always_comb begin
    nxt      = cur;
    div_nxt  = div_cnt;
    en_nxt   = 1'b0;
    clrn_nxt = 1'b1;
    if (req_edge[2]) begin
      nxt      = IDLE;
      div_nxt  = '0;
      clrn_nxt = 1'b0;
    end else begin
      case (cur)
        IDLE: begin
          div_nxt = '0;
          if (req_edge[0]) nxt = RUN;
        end
        RUN: begin
          if (req_edge[1]) begin
            nxt = PAUSE;
          end else if (tick) begin
            div_nxt = '0;
            if ((count == 8'hFF) && !wrap_en) nxt = DONE;
            else en_nxt = 1'b1;
          end else begin
            div_nxt = div_cnt + DIV_W'(1);
          end
        end
        PAUSE: begin
          if (req_edge[0]) nxt = RUN;
        end
        DONE: begin
          div_nxt = '0;
        end
        default: begin
          nxt     = IDLE;
          div_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      cur        <= IDLE;
      div_cnt    <= '0;
      cnt_enable <= 1'b0;
      cnt_clearn <= 1'b1;
      done       <= 1'b0;
    end else begin
      cur        <= nxt;
      div_cnt    <= div_nxt;
      cnt_enable <= en_nxt;
      cnt_clearn <= clrn_nxt;
      done       <= (nxt == DONE);
    end
  end

  assign state = cur;

endmodule
